// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one bit per clock.
// Result packs six BCD digits into bcd_out[31:8]; bcd_out[7:0] is always 0.
//
// Ports:
//   clk      in   system clock
//   nRESET   in   asynchronous active-low reset
//   start    in   request conversion (accepted only when idle)
//   bin_in   in   unsigned binary value, sampled on accept
//   busy     out  high while shifting
//   done     out  one-cycle pulse when bcd_out has been updated
//   overflow out  last accepted bin_in exceeded MAX_VAL (saturated)
//   bcd_out  out  {d5,d4,d3,d2,d1,d0,8'h00}
module bin2bcd_seq #(
   parameter int BIN_W   = 20,
   parameter int MAX_VAL = 999999
) (
   input  logic             clk,
   input  logic             nRESET,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [31:0]      bcd_out
);

   localparam int CNT_W = $clog2(BIN_W);
   localparam logic [BIN_W-1:0] W_MAX = BIN_W'(MAX_VAL);
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [BIN_W-1:0] r_bin;
   logic [23:0]      r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [23:0]      r_bcd;
   logic             r_busy;
   logic             r_done;
   logic             r_ovf;

   logic             w_big;
   logic [23:0]      w_next;

   function automatic logic [3:0] f_adj(input logic [3:0] n);
      f_adj = (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign w_big = (bin_in > W_MAX);

   // Adjust every nibble, then shift left with the binary MSB entering
   // at bit 0. The top nibble's MSB falls off the end of the shift.
   assign w_next = {3'(f_adj(r_acc[23:20])),
                    f_adj(r_acc[19:16]),
                    f_adj(r_acc[15:12]),
                    f_adj(r_acc[11:8]),
                    f_adj(r_acc[7:4]),
                    f_adj(r_acc[3:0]),
                    r_bin[BIN_W-1]};

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_state <= IDLE;
         r_bin   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_bin   <= w_big ? W_MAX : bin_in;
                  r_ovf   <= w_big;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_acc <= w_next;
               r_bin <= {r_bin[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == W_LAST) begin
                  r_bcd   <= w_next;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_done <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_ovf;
   assign bcd_out  = {r_bcd, 8'h00};

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Checks latency, results, saturation, start handling and async reset.
module tb_bin2bcd_seq;

   logic        clk;
   logic        nRESET;
   logic        start;
   logic [19:0] bin_in;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [31:0] bcd_out;

   int          n_chk;
   int          n_fail;
   logic [31:0] last_bcd;

   bin2bcd_seq #(.BIN_W(20), .MAX_VAL(999999)) dut (
      .clk      (clk),
      .nRESET   (nRESET),
      .start    (start),
      .bin_in   (bin_in),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .bcd_out  (bcd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic convert(input string tag, input logic [19:0] val,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
      int lat;
      lat = 0;
      bin_in = val;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      bin_in = 20'(32'hA5A5A);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (n == 10)
            chk({tag, "_hold"}, bcd_out, last_bcd);
         if (done) begin
            lat = n;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'd20);
      chk({tag, "_bcd"}, bcd_out, exp_bcd);
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
      tick();
      chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
      last_bcd = exp_bcd;
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      last_bcd = 32'h0;
      nRESET   = 1'b0;
      start    = 1'b0;
      bin_in   = 20'd0;
      repeat (3) tick();
      chk("rst_out", {busy, done, overflow, 29'd0}, 32'd0);
      chk("rst_bcd", bcd_out, 32'h0);
      nRESET = 1'b1;
      tick();

      convert("t1", 20'd123456, 32'h12345600, 1'b0);
      convert("t2a", 20'd0, 32'h00000000, 1'b0);
      convert("t2b", 20'd999999, 32'h99999900, 1'b0);
      convert("t3a", 20'hFFFFF, 32'h99999900, 1'b1);
      convert("t3b", 20'd5, 32'h00000500, 1'b0);

      // start while busy is ignored
      bin_in = 20'd777;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (k == 5) begin
            bin_in = 20'd42;
            start  = 1'b1;
         end
         tick();
         if (k == 5)
            start = 1'b0;
         chk("t4_done", {31'd0, done}, (k == 20) ? 32'd1 : 32'd0);
         if (k == 20)
            chk("t4_bcd", bcd_out, 32'h00077700);
      end
      chk("t4_end", bcd_out, 32'h00077700);

      // start held high: back-to-back conversions
      bin_in = 20'd1;
      start  = 1'b1;
      tick();
      for (int k = 1; k <= 62; k++) begin
         tick();
         chk("t5_done", {31'd0, done},
             (k == 20 || k == 41 || k == 62) ? 32'd1 : 32'd0);
         if (k == 20) chk("t5_bcd1", bcd_out, 32'h00000100);
         if (k == 41) chk("t5_bcd2", bcd_out, 32'h00000200);
         if (k == 62) chk("t5_bcd3", bcd_out, 32'h00000300);
         bin_in = (k < 21) ? 20'd2 : 20'd3;
         if (k == 62)
            start = 1'b0;
      end
      tick();
      chk("t5_idle", {31'd0, busy}, 32'd0);

      // async reset mid-conversion
      bin_in = 20'd999;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (10) tick();
      chk("t6_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      nRESET = 1'b0;
      #1;
      chk("t6_rst_out", {busy, done, overflow, 29'd0}, 32'd0);
      chk("t6_rst_bcd", bcd_out, 32'h0);
      #2;
      nRESET   = 1'b1;
      last_bcd = 32'h0;
      convert("t6", 20'd31, 32'h00003100, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
